// File: rtl/addsub_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin add/sub arbiter.
package addsub_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StAck  = 2'b10
  } state_e;

  localparam logic ADDSUB_ADD = 1'b1;
  localparam logic ADDSUB_SUB = 1'b0;

endpackage

// File: rtl/addsub_rr_arbiter_rr_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping.
module addsub_rr_arbiter_rr_picker #(
  parameter int unsigned NReq = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int unsigned      pos;
  logic [IdxW-1:0]  pos_idx;

  always_comb begin
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= NReq) pos = pos - NReq;
      pos_idx = IdxW'(pos);
      if (!any_o && req_i[pos_idx]) begin
        any_o = 1'b1;
        idx_o = pos_idx;
      end
    end
  end

endmodule

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter sequencing N_REQ requesters onto one registered add/sub datapath.
module addsub_rr_arbiter
  import addsub_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       mode_i,
  input  logic [N_REQ*WIDTH-1:0] a_i,
  input  logic [N_REQ*WIDTH-1:0] b_i,
  output logic [N_REQ-1:0]       ready_o,
  output logic [WIDTH-1:0]       res_o,
  output logic [IDX_W-1:0]       grant_o,
  output logic                   busy_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               op_mode_q, op_mode_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [N_REQ-1:0]   ready_q, ready_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  addsub_rr_arbiter_rr_picker #(
    .NReq (N_REQ),
    .IdxW (IDX_W)
  ) u_picker (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    op_mode_d = op_mode_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    ready_d   = '0;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d   = pick_idx;
          op_mode_d = mode_i[pick_idx];
          op_a_d    = a_i[32'(pick_idx)*WIDTH +: WIDTH];
          op_b_d    = b_i[32'(pick_idx)*WIDTH +: WIDTH];
          state_d   = StExec;
        end
      end
      StExec: begin
        // Results wrap modulo 2^WIDTH; carry and borrow are dropped.
        res_d            = (op_mode_q == ADDSUB_ADD) ? op_a_q + op_b_q : op_a_q - op_b_q;
        ready_d[grant_q] = 1'b1;
        state_d          = StAck;
      end
      StAck: begin
        ptr_d   = (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + IDX_W'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      grant_q   <= '0;
      op_mode_q <= ADDSUB_SUB;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      ready_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      op_mode_q <= op_mode_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_q     <= res_d;
      ready_q   <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign res_o   = res_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != StIdle);

endmodule
